// File: rtl/hs_pkg.sv
// Shared types and defaults for the req/ack handshake initiator.
package hs_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } hs_state_t;

    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/hs_sync_fifo.sv
// Circular-buffer FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module hs_sync_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/hs_initiator.sv
// Buffers upstream bytes and delivers each to a req/ack slave with a four-phase
// handshake, retrying any byte whose ack does not arrive within TIMEOUT_CYCLES.
module hs_initiator
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack,
    input  logic              slave_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       sent_count
);

    localparam int unsigned    TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

    hs_state_t         state;
    logic [TW-1:0]     tcnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    // The head is only released once the slave has acknowledged it; a timeout keeps it for retry.
    assign pop      = (state == S_REQ) && ack;
    assign busy     = (state != S_IDLE) || !fifo_empty;

    hs_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            req         <= 1'b0;
            data_out    <= '0;
            timeout_err <= 1'b0;
            sent_count  <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty && slave_ready) begin
                        req      <= 1'b1;
                        data_out <= fifo_head;
                        tcnt     <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        req        <= 1'b0;
                        sent_count <= sent_count + 16'd1;
                        state      <= S_RELEASE;
                    end else if (tcnt == TLAST) begin
                        req         <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_RELEASE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RELEASE: begin
                    req <= 1'b0;
                    if (!ack) state <= S_IDLE;
                end
                default: begin
                    req   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_initiator.sv
// Directed bench for hs_initiator with a simple two-cycle-latency req/ack slave model.
module tb_hs_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        req;
    logic [7:0]  data_out;
    logic        ack;
    logic        slave_ready = 1'b1;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sent_count;

    int tests = 0;
    int fails = 0;
    bit slave_en = 1'b1;
    logic req_d;
    logic [7:0] cap_q [$];

    hs_initiator #(
        .DATA_W         (8),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req         (req),
        .data_out    (data_out),
        .ack         (ack),
        .slave_ready (slave_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    // Slave: captures data on req rise, raises ack two edges after req, drops it one edge after req falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= 1'b0;
            ack   <= 1'b0;
        end else begin
            req_d <= req;
            ack   <= slave_en && req_d && req;
            if (req && !req_d) cap_q.push_back(data_out);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        slave_ready = 1'b1;
        slave_en    = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n = 0;
        while ((busy || ack) && n < max_cyc) begin
            tick();
            n++;
        end
        tests++;
        if (busy || ack) begin
            fails++;
            $display("FAIL %s_drain: busy=%b ack=%b, required idle within %0d cycles", name, busy, ack, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++; if (req !== 1'b0)         begin fails++; $display("FAIL reset_req: got %b want 0", req); end
        tests++; if (data_out !== 8'h00)   begin fails++; $display("FAIL reset_data: got %h want 00", data_out); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", sent_count); end
        tests++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        do_reset();
        base = cap_q.size();
        push_byte(8'hA5);
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL single_req_early: got %b want 0", req); end
        tick();
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL single_req_rise: got %b want 1", req); end
        tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", data_out); end
        tick();
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL single_ack_early: got %b want 0", ack); end
        tick();
        tests++; if (ack !== 1'b1 || req !== 1'b1) begin fails++; $display("FAIL single_ack_rise: ack=%b req=%b want 1 1", ack, req); end
        tick();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL single_req_fall: got %b want 0", req); end
        tests++; if (sent_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d want 1", sent_count); end
        tick();
        tests++; if (ack !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_release: ack=%b busy=%b want 0 1", ack, busy); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b want 0", busy); end
        tests++;
        if (cap_q.size() != base + 1 || cap_q[base] !== 8'hA5) begin
            fails++; $display("FAIL single_capture: got %0d bytes, want one byte a5", cap_q.size() - base);
        end
    endtask

    task automatic test_burst();
        int base;
        int acc = 0;
        int cyc = 0;
        logic rdy;
        do_reset();
        base = cap_q.size();
        in_valid = 1'b1;
        in_data  = 8'h01;
        while (acc < 6 && cyc < 300) begin
            rdy = in_ready;
            tick();
            cyc++;
            if (rdy) begin
                acc++;
                if (acc == 4) begin
                    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL burst_full: in_ready=%b want 0 after 4 pushes", in_ready); end
                end
                if (acc < 6) in_data = 8'(acc + 1);
                else         in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++; if (acc != 6) begin fails++; $display("FAIL burst_accept: accepted %0d want 6", acc); end
        wait_done(300, "burst");
        tests++; if (sent_count !== 16'd6) begin fails++; $display("FAIL burst_count: got %0d want 6", sent_count); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_q.size() <= base + i || cap_q[base + i] !== 8'(i + 1)) begin
                fails++; $display("FAIL burst_order[%0d]: want %h", i, 8'(i + 1));
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 1;
        int n = 0;
        do_reset();
        slave_en = 1'b0;
        push_byte(8'h5A);
        tick();
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_req_rise: got %b want 1", req); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!req) break;
            hi++;
        end
        tests++; if (hi != 8) begin fails++; $display("FAIL to_req_width: high %0d cycles want 8", hi); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
        tick();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_pulse_width: got %b want 0", timeout_err); end
        while (!req && n < 20) begin
            tick();
            n++;
        end
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_retry: req=%b want 1", req); end
        tests++; if (data_out !== 8'h5A) begin fails++; $display("FAIL to_retry_data: got %h want 5a", data_out); end
        tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL to_count: got %0d want 0", sent_count); end
    endtask

    task automatic test_not_ready();
        bit saw_req = 1'b0;
        bit saw_to = 1'b0;
        do_reset();
        slave_ready = 1'b0;
        push_byte(8'h3C);
        repeat (50) begin
            tick();
            if (req) saw_req = 1'b1;
            if (timeout_err) saw_to = 1'b1;
        end
        tests++; if (saw_req !== 1'b0) begin fails++; $display("FAIL nr_req: req seen 1, want 0"); end
        tests++; if (saw_to !== 1'b0) begin fails++; $display("FAIL nr_timeout: pulse seen, want none"); end
        slave_ready = 1'b1;
        tick();
        tests++; if (req !== 1'b1 || data_out !== 8'h3C) begin fails++; $display("FAIL nr_go: req=%b data=%h want 1 3c", req, data_out); end
        wait_done(50, "nr");
        tests++; if (sent_count !== 16'd1) begin fails++; $display("FAIL nr_count: got %0d want 1", sent_count); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        while (!(req && sent_count == 16'd1) && n < 100) begin
            tick();
            n++;
        end
        tests++; if (!(req && sent_count == 16'd1)) begin fails++; $display("FAIL rm_setup: req=%b count=%0d want 1 1", req, sent_count); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rm_req: got %b want 0", req); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL rm_data: got %h want 00", data_out); end
        tests++; if (sent_count !== 16'd0) begin fails++; $display("FAIL rm_count: got %0d want 0", sent_count); end
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rm_idle: in_ready=%b busy=%b want 1 0", in_ready, busy); end
        tick();
        rst_n = 1'b1;
        tick();
        push_byte(8'h77);
        tick();
        wait_done(50, "rm");
        tests++; if (sent_count !== 16'd1) begin fails++; $display("FAIL rm_after_count: got %0d want 1", sent_count); end
        tests++; if (cap_q[cap_q.size() - 1] !== 8'h77) begin fails++; $display("FAIL rm_after_data: got %h want 77", cap_q[cap_q.size() - 1]); end
    endtask

    task automatic test_push_pop();
        int base;
        int n = 0;
        logic [7:0] exp;
        do_reset();
        base = cap_q.size();
        slave_ready = 1'b0;
        push_byte(8'h21);
        push_byte(8'h22);
        slave_ready = 1'b1;
        while (!ack && n < 20) begin
            tick();
            n++;
        end
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL pp_ack: got %b want 1", ack); end
        in_valid    = 1'b1;
        in_data     = 8'h23;
        slave_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++; if (sent_count !== 16'd1) begin fails++; $display("FAIL pp_pop: count=%0d want 1", sent_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL pp_room2: in_ready=%b want 1", in_ready); end
        push_byte(8'h24);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL pp_room1: in_ready=%b want 1", in_ready); end
        push_byte(8'h25);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL pp_full: in_ready=%b want 0", in_ready); end
        slave_ready = 1'b1;
        wait_done(200, "pp");
        tests++; if (sent_count !== 16'd5) begin fails++; $display("FAIL pp_count: got %0d want 5", sent_count); end
        for (int i = 0; i < 5; i++) begin
            exp = 8'(8'h21 + i);
            tests++;
            if (cap_q.size() <= base + i || cap_q[base + i] !== exp) begin
                fails++; $display("FAIL pp_order[%0d]: want %h", i, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_not_ready();
        test_reset_mid();
        test_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
